cpu_pipe_core: RTL and testbench
================================

// Module: cpu_pipe_core
// PURPOSE
//  Parametrised two-stage (fetch / execute-writeback) processor core: next generation of the prak4 cpu.
//  Adds a loadable program memory, a start/halt control FSM, a zero flag for conditional jump,
//  LDI/HALT opcodes, squash on taken jump and a debug register read port.
//  Sits under the lab top level; the testbench loads a program, pulses start and checks registers.
// PARAMETERS
//  DATA_WIDTH       8    register/data width, >=8; LDI immediate is zero-extended to it
//  PMEM_ADDR_WIDTH  8    program memory address width, <=8; depth = 2**PMEM_ADDR_WIDTH
//  CNT_WIDTH        16   width of the retired-instruction counter
//  (localparams: CMD_WIDTH=16, REG_NUM=16, REG_ADDR_WIDTH=4; fixed by the encoding)
// PORTS
//  clk         in   1                clock, all state on posedge
//  reset       in   1                synchronous, active-high; overrides every other input
//  start       in   1                one-cycle request; accepted only in IDLE or HALTED
//  prog_we     in   1                program memory write enable; honoured only when not RUN
//  prog_addr   in   PMEM_ADDR_WIDTH  program memory write address
//  prog_data   in   16               instruction word to write
//  dbg_addr    in   4                debug register index
//  dbg_data    out  DATA_WIDTH       combinational read of R[dbg_addr]
//  busy        out  1                1 while state==RUN
//  halted      out  1                1 while state==HALTED
//  zero_flag   out  1                Z flag
//  retired     out  CNT_WIDTH        count of executed, non-squashed instructions (NOP included)
// BEHAVIOUR
//  Encoding [15:12]=op, [11:8]=A, [7:4]=B, [3:0]=C; imm8=[7:0].
//   0000 NOP; 0001 MUL R[C]=low DATA_WIDTH bits of R[A]*R[B]; 0010 XNOR R[C]=~(R[A]^R[B]);
//   0011 MOVE R[A]=R[B]; 0100 JNZ if Z==0 then pc=imm8[PMEM_ADDR_WIDTH-1:0];
//   0101 LDI R[A]=zero-extended imm8; 0110 HALT; 0111-1111 execute as NOP.
//  Z is updated by MUL and XNOR only (Z = result==0); other ops leave it unchanged.
//  FSM: IDLE -start-> RUN; RUN -HALT executed-> HALTED; HALTED -start-> RUN. No other transitions.
//  Entering RUN: pc<=0, ir_valid<=0; registers and Z keep their values; retired is not cleared.
//  Fetch edge (RUN): ir<=pmem[pc], ir_valid<=1, pc<=pc+1, wrapping from 2**PMEM_ADDR_WIDTH-1 to 0.
//  Execute edge (RUN, ir_valid): regfile read combinational from ir; write and Z update on the same edge.
//  Latency: the instruction at address 0 writes back on the 2nd edge after the start edge.
//  Back-to-back dependent ops need no forwarding: a write lands before the next execute reads.
//  Taken JNZ: pc<=target, ir_valid<=0 (squash the fetched word); 1 bubble; squashed word not counted.
//  Not-taken JNZ: no bubble.
//  HALT: state<=HALTED and ir_valid<=0 on its execute edge; fetched successor squashed; pc frozen.
//  prog_we while RUN: ignored. prog_we and start on the same IDLE edge: both honoured (write first).
//  start while RUN: ignored.
//  Reset: state=IDLE, pc=0, ir=0, ir_valid=0, all R=0, Z=1, retired=0; busy=0, halted=0.
//  Reset mid-RUN: everything above on that edge; program memory contents are not reset.
//  retired saturates at all-ones.
// STRUCTURE
//  Package cpu_pkg: opcode constants, field bit positions, CMD_WIDTH, FSM state encoding.
//  Sub-module cpu_regfile_2r1w: 16 x DATA_WIDTH, 2 combinational read ports, 1 write port,
//   synchronous reset to 0; the debug port reuses read port B when no instruction is valid,
//   otherwise a third read mux.
//  Program memory: inferred array in this module, written only through prog_*.
// TESTING
//  1. Reset then LDI R1,3; LDI R2,5; MUL R1,R2->R3; HALT; start
//      -> R3=15 (dbg), Z=0, halted=1, retired=4, busy low after HALT.
//  2. LDI R1,0xF0; LDI R2,0x0F; XNOR R1,R2->R4; HALT
//      -> R4=0x00 for DATA_WIDTH=8, Z=1; MUL 0x10*0x10 -> 0x00, Z=1.
//  3. Loop: LDI R1,1; XNOR R1,R0->R5 (Z=0); JNZ 5; LDI R6,9 (squashed); ...; addr5 HALT
//      -> R6 unchanged 0, retired excludes squashed word.
//  4. Start pulse during RUN, prog_we during RUN to address 0
//      -> both ignored; memory word at 0 unchanged on rerun.
//  5. Assert reset 3 cycles into RUN
//      -> next edge: busy=0, pc=0, all R=0, Z=1; reloaded program runs correctly.
//  6. PMEM_ADDR_WIDTH=3: 8 NOPs with no HALT -> pc wraps 7->0; retired keeps counting.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the two-stage cpu core: instruction field layout,
// opcodes and control-FSM state encoding.
package cpu_pkg;

    localparam int CMD_WIDTH      = 16;
    localparam int REG_NUM        = 16;
    localparam int REG_ADDR_WIDTH = 4;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int A_MSB   = 11;
    localparam int A_LSB   = 8;
    localparam int B_MSB   = 7;
    localparam int B_LSB   = 4;
    localparam int C_MSB   = 3;
    localparam int C_LSB   = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes 7..15 are not listed and execute as NOP.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MUL  = 4'h1,
        OP_XNOR = 4'h2,
        OP_MOVE = 4'h3,
        OP_JNZ  = 4'h4,
        OP_LDI  = 4'h5,
        OP_HALT = 4'h6
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_regfile_2r1w.sv
// 16-entry register file: two combinational operand read ports, a third
// combinational read port for debug, one synchronous write port.
module cpu_regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0]     rd_data_a,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0]     rd_data_b,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_c,
    output logic [DATA_WIDTH-1:0]     rd_data_c
);

    logic [DATA_WIDTH-1:0] regs_reg [REG_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (we && (wr_addr == REG_ADDR_WIDTH'(gi))) begin
                    regs_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data_a = regs_reg[rd_addr_a];
    assign rd_data_b = regs_reg[rd_addr_b];
    assign rd_data_c = regs_reg[rd_addr_c];

endmodule

// File: rtl/cpu_pipe_core.sv
// Two-stage (fetch / execute-writeback) core with loadable program memory,
// start/halt control FSM, zero flag, squash on taken jump and debug read port.
module cpu_pipe_core
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int PMEM_ADDR_WIDTH = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       prog_we,
    input  logic [PMEM_ADDR_WIDTH-1:0] prog_addr,
    input  logic [CMD_WIDTH-1:0]       prog_data,
    input  logic [REG_ADDR_WIDTH-1:0]  dbg_addr,
    output logic [DATA_WIDTH-1:0]      dbg_data,
    output logic                       busy,
    output logic                       halted,
    output logic                       zero_flag,
    output logic [CNT_WIDTH-1:0]       retired
);

    localparam int PMEM_DEPTH = 2 ** PMEM_ADDR_WIDTH;

    state_e                     state_reg, state_next;
    logic [PMEM_ADDR_WIDTH-1:0] pc_reg;
    logic [CMD_WIDTH-1:0]       ir_reg;
    logic                       ir_valid_reg;
    logic                       z_reg;
    logic [CNT_WIDTH-1:0]       retired_reg;
    logic [CMD_WIDTH-1:0]       pmem [PMEM_DEPTH];

    logic                       exec_valid;
    logic                       start_accept;
    opcode_e                    op;
    logic                       rf_we;
    logic [REG_ADDR_WIDTH-1:0]  rf_waddr;
    logic [DATA_WIDTH-1:0]      rf_wdata;
    logic                       z_we;
    logic                       jnz_taken;
    logic                       halt_exec;
    logic [REG_ADDR_WIDTH-1:0]  rd_addr_b;
    logic [DATA_WIDTH-1:0]      rd_data_a, rd_data_b, rd_data_c;
    logic [DATA_WIDTH-1:0]      alu_mul, alu_xnor;

    assign exec_valid   = (state_reg == ST_RUN) && ir_valid_reg;
    assign start_accept = start && (state_reg != ST_RUN);
    assign op           = opcode_e'(ir_reg[OP_MSB:OP_LSB]);

    // Operand port B doubles as the debug port while no instruction is in flight.
    assign rd_addr_b = ir_valid_reg ? ir_reg[B_MSB:B_LSB] : dbg_addr;
    assign dbg_data  = ir_valid_reg ? rd_data_c : rd_data_b;

    cpu_regfile_2r1w #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .wr_addr  (rf_waddr),
        .wr_data  (rf_wdata),
        .rd_addr_a(ir_reg[A_MSB:A_LSB]),
        .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b),
        .rd_addr_c(dbg_addr),
        .rd_data_c(rd_data_c)
    );

    assign alu_mul  = rd_data_a * rd_data_b;
    assign alu_xnor = ~(rd_data_a ^ rd_data_b);

    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = ir_reg[A_MSB:A_LSB];
        rf_wdata  = '0;
        z_we      = 1'b0;
        jnz_taken = 1'b0;
        halt_exec = 1'b0;
        case (op)
            OP_MUL: begin
                rf_we    = exec_valid;
                rf_waddr = ir_reg[C_MSB:C_LSB];
                rf_wdata = alu_mul;
                z_we     = exec_valid;
            end
            OP_XNOR: begin
                rf_we    = exec_valid;
                rf_waddr = ir_reg[C_MSB:C_LSB];
                rf_wdata = alu_xnor;
                z_we     = exec_valid;
            end
            OP_MOVE: begin
                rf_we    = exec_valid;
                rf_wdata = rd_data_b;
            end
            OP_LDI: begin
                rf_we    = exec_valid;
                rf_wdata = DATA_WIDTH'(ir_reg[IMM_MSB:IMM_LSB]);
            end
            OP_JNZ:  jnz_taken = exec_valid && !z_reg;
            OP_HALT: halt_exec = exec_valid;
            default: ;
        endcase
    end

    // Control FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_RUN;
            ST_RUN:    if (halt_exec) state_next = ST_HALTED;
            ST_HALTED: if (start) state_next = ST_RUN;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_reg == ST_RUN);
        halted = (state_reg == ST_HALTED);
    end

    // Fetch stage, flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= '0;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            z_reg        <= 1'b1;
            retired_reg  <= '0;
        end else if (start_accept) begin
            pc_reg       <= '0;
            ir_valid_reg <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            if (exec_valid && (retired_reg != '1)) begin
                retired_reg <= retired_reg + CNT_WIDTH'(1);
            end
            if (z_we) begin
                z_reg <= (rf_wdata == '0);
            end
            if (halt_exec) begin
                ir_valid_reg <= 1'b0;
            end else if (jnz_taken) begin
                pc_reg       <= ir_reg[PMEM_ADDR_WIDTH-1:0];
                ir_valid_reg <= 1'b0;
            end else begin
                ir_reg       <= pmem[pc_reg];
                ir_valid_reg <= 1'b1;
                pc_reg       <= pc_reg + PMEM_ADDR_WIDTH'(1);
            end
        end
    end

    // Program memory survives reset; loading is locked out while running.
    always_ff @(posedge clk) begin
        if (!reset && prog_we && (state_reg != ST_RUN)) begin
            pmem[prog_addr] <= prog_data;
        end
    end

    assign zero_flag = z_reg;
    assign retired   = retired_reg;

endmodule

// File: tb/tb_cpu_pipe_core.sv
// Directed bench for cpu_pipe_core: table-driven programs plus hand-written
// sequences for run-time start/prog_we, mid-run reset, pc wrap and saturation.
module tb_cpu_pipe_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [3:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
    logic        busy, halted, zero_flag;
    logic [15:0] retired;

    logic        start_w3 = 1'b0;
    logic        prog_we_w3 = 1'b0;
    logic [2:0]  prog_addr_w3 = '0;
    logic [15:0] prog_data_w3 = '0;
    logic [3:0]  dbg_addr_w3 = '0;
    logic [7:0]  dbg_data_w3;
    logic        busy_w3, halted_w3, zero_flag_w3;
    logic [3:0]  retired_w3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_pipe_core #(.DATA_WIDTH(8), .PMEM_ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .busy(busy), .halted(halted),
        .zero_flag(zero_flag), .retired(retired)
    );

    cpu_pipe_core #(.DATA_WIDTH(8), .PMEM_ADDR_WIDTH(3), .CNT_WIDTH(4)) dut_w3 (
        .clk(clk), .reset(reset), .start(start_w3), .prog_we(prog_we_w3),
        .prog_addr(prog_addr_w3), .prog_data(prog_data_w3), .dbg_addr(dbg_addr_w3),
        .dbg_data(dbg_data_w3), .busy(busy_w3), .halted(halted_w3),
        .zero_flag(zero_flag_w3), .retired(retired_w3)
    );

    typedef logic [7:0][15:0] prog_t;

    typedef struct {
        prog_t      prog;
        int         reg_a;
        logic [7:0] val_a;
        int         reg_b;
        logic [7:0] val_b;
        logic       exp_z;
        int         exp_ret;
        int         exp_cyc;
    } vec_t;

    vec_t vecs [5];

    function automatic prog_t mk(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
        prog_t p;
        p[0] = w0; p[1] = w1; p[2] = w2; p[3] = w3;
        p[4] = w4; p[5] = w5; p[6] = w6; p[7] = w7;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input prog_t p);
        for (int i = 0; i < 8; i++) begin
            prog_we = 1'b1;
            prog_addr = 8'(i);
            prog_data = p[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halted(output int n);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (halted) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic read_reg(input int idx, output logic [7:0] val);
        dbg_addr = 4'(idx);
        #1;
        val = dbg_data;
    endtask

    logic [7:0]  rv;
    int          ncyc;
    prog_t       prog1;

    initial begin
        prog1 = mk(16'h5103, 16'h5205, 16'h1123, 16'h6000, 0, 0, 0, 0);
        // LDI R1,3; LDI R2,5; MUL R1,R2->R3; HALT
        vecs[0] = '{prog1, 3, 8'd15, 1, 8'd3, 1'b0, 4, 5};
        // XNOR R0,R0->R7 (Z=0); LDI R1,F0; LDI R2,0F; XNOR R1,R2->R4; HALT
        vecs[1] = '{mk(16'h2007, 16'h51F0, 16'h520F, 16'h2124, 16'h6000, 0, 0, 0),
                    4, 8'h00, 7, 8'hFF, 1'b1, 5, 6};
        // XNOR R0,R0->R7; LDI R1,10; MUL R1,R1->R5; HALT
        vecs[2] = '{mk(16'h2007, 16'h5110, 16'h1115, 16'h6000, 0, 0, 0, 0),
                    5, 8'h00, 1, 8'h10, 1'b1, 4, 5};
        // LDI R1,1; XNOR R1,R0->R5; JNZ 5 (taken); LDI R6,9; LDI R6,7; HALT
        vecs[3] = '{mk(16'h5101, 16'h2105, 16'h4005, 16'h5609, 16'h5607, 16'h6000, 0, 0),
                    6, 8'h00, 5, 8'hFE, 1'b0, 4, 6};
        // JNZ 3 (not taken, Z=1 from reset); LDI R6,9; HALT; LDI R6,7; HALT
        vecs[4] = '{mk(16'h4003, 16'h5609, 16'h6000, 16'h5607, 16'h6000, 0, 0, 0),
                    6, 8'h09, 0, 8'h00, 1'b1, 3, 4};

        do_reset();
        check("reset busy", 32'(busy), 0);
        check("reset halted", 32'(halted), 0);
        check("reset zero", 32'(zero_flag), 1);
        check("reset retired", 32'(retired), 0);
        $display("reset: busy=%0d halted=%0d z=%0d retired=%0d", busy, halted, zero_flag, retired);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            load(vecs[v].prog);
            pulse_start();
            wait_halted(ncyc);
            check($sformatf("vec%0d cycles", v), 32'(ncyc), 32'(vecs[v].exp_cyc));
            check($sformatf("vec%0d halted", v), 32'(halted), 1);
            check($sformatf("vec%0d busy", v), 32'(busy), 0);
            check($sformatf("vec%0d zero", v), 32'(zero_flag), 32'(vecs[v].exp_z));
            check($sformatf("vec%0d retired", v), 32'(retired), 32'(vecs[v].exp_ret));
            read_reg(vecs[v].reg_a, rv);
            check($sformatf("vec%0d R%0d", v, vecs[v].reg_a), 32'(rv), 32'(vecs[v].val_a));
            read_reg(vecs[v].reg_b, rv);
            check($sformatf("vec%0d R%0d", v, vecs[v].reg_b), 32'(rv), 32'(vecs[v].val_b));
            $display("vector %0d: cycles=%0d retired=%0d z=%0d", v, ncyc, retired, zero_flag);
        end

        // start and prog_we while running are both ignored
        do_reset();
        load(prog1);
        pulse_start();
        tick();
        tick();
        start = 1'b1; prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h5877;
        tick();
        start = 1'b0; prog_we = 1'b0;
        wait_halted(ncyc);
        check("run-ignore cycles", 32'(ncyc), 2);
        read_reg(3, rv);
        check("run-ignore R3", 32'(rv), 15);
        pulse_start();
        wait_halted(ncyc);
        check("rerun cycles", 32'(ncyc), 5);
        read_reg(8, rv);
        check("rerun R8", 32'(rv), 0);
        read_reg(1, rv);
        check("rerun R1", 32'(rv), 3);
        check("rerun retired", 32'(retired), 8);
        $display("run-ignore: rerun retired=%0d", retired);

        // reset three cycles into a run
        pulse_start();
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", 32'(busy), 0);
        check("midreset halted", 32'(halted), 0);
        check("midreset zero", 32'(zero_flag), 1);
        check("midreset retired", 32'(retired), 0);
        read_reg(1, rv);
        check("midreset R1", 32'(rv), 0);
        read_reg(3, rv);
        check("midreset R3", 32'(rv), 0);
        pulse_start();
        wait_halted(ncyc);
        check("post-reset cycles", 32'(ncyc), 5);
        read_reg(3, rv);
        check("post-reset R3", 32'(rv), 15);
        check("post-reset retired", 32'(retired), 4);
        $display("midreset: rerun R3=%0d retired=%0d", rv, retired);

        // 8-word memory: XNOR R1,R0->R1 at address 0 toggles R1 on every pass
        do_reset();
        for (int i = 0; i < 8; i++) begin
            prog_we_w3 = 1'b1;
            prog_addr_w3 = 3'(i);
            prog_data_w3 = (i == 0) ? 16'h2101 : 16'h0000;
            tick();
        end
        prog_we_w3 = 1'b0;
        start_w3 = 1'b1;
        tick();
        start_w3 = 1'b0;
        dbg_addr_w3 = 4'd1;
        for (int i = 0; i < 9; i++) tick();
        check("w3 pass1 R1", 32'(dbg_data_w3), 32'hFF);
        check("w3 pass1 retired", 32'(retired_w3), 8);
        check("w3 pass1 zero", 32'(zero_flag_w3), 0);
        tick();
        check("w3 wrap R1", 32'(dbg_data_w3), 32'h00);
        check("w3 wrap retired", 32'(retired_w3), 9);
        check("w3 wrap zero", 32'(zero_flag_w3), 1);
        for (int i = 0; i < 20; i++) tick();
        check("w3 saturate retired", 32'(retired_w3), 15);
        check("w3 still busy", 32'(busy_w3), 1);
        $display("w3: retired=%0d busy=%0d", retired_w3, busy_w3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
